control_fsm: RTL
================

# control_fsm

Multi-cycle fetch/decode/execute sequencer for the 8-bit core. It owns the 6-bit PC, the instruction register and the NZP condition-code register. It fetches 16-bit instructions over a stallable memory handshake and addresses the register file. It drives the ALU control inputs (`alu_op`, `source_sel`, `ins_immediate`, `pc`) and consumes the ALU's `negative`/`zero`/`positive` flags.

## Interface
Parameters:
- `PC_W`, 6: PC width; instruction space is 64 words.
- `IW`, 16: instruction width.

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  active-low reset, synchronous to `clk`. One clock; reset is synchronous and active-low.
- `imem_addr`  out  6  fetch address (equals `pc`).
- `imem_rd`  out  1  fetch request.
- `imem_ack`  in  1  `imem_data` valid this cycle.
- `imem_data`  in  16  instruction word.
- `reg_sr1_addr`, `reg_sr2_addr`, `reg_dr_addr`  out  3 each  register file addresses.
- `reg_we`  out  1  register write strobe; write data is the ALU result.
- `alu_op`  out  2  00 add, 01 and, 10 not.
- `source_sel`  out  2  00 immediate, 10 register, 01 PC.
- `ins_immediate`  out  6  IR[5:0].
- `pc`  out  6  current instruction address.
- `negative`, `zero`, `positive`  in  1 each  ALU flags.
- `nzp`  out  3  condition register {N,Z,P}.
- `halted`  out  1  HALT executed.

## Operation
Instruction format:
- [15:12] opcode
- [11:9] dr, or nzp mask for BR
- [8:6] sr1
- [5] immediate flag
- [4:0] imm5
- [2:0] sr2
- [5:0] imm6

Opcodes:
- 0000 ADD: `alu_op`=00; `source_sel`=00 if IR[5] else 10.
- 0001 AND: `alu_op`=01; `source_sel` as ADD.
- 0010 NOT: `alu_op`=10; `source_sel` as ADD.
- 0011 LEA: `alu_op`=00, `source_sel`=01.
- 0100 BR: taken iff (IR[11:9] & nzp) != 0.
- 1111 HALT.
- All other opcodes: NOP.

State machine:
- FETCH: `imem_rd`=1. On `imem_ack`, IR <= `imem_data` and go to DECODE. Otherwise hold FETCH with `imem_addr` stable.
- DECODE: drive `reg_sr1_addr`=IR[8:6] and `reg_sr2_addr`=IR[2:0]. The register file read is synchronous, so data is valid in the next cycle. Go to EXECUTE.
- EXECUTE: ALU controls are valid this cycle. Actions by opcode:
  - ADD/AND/NOT/LEA: `reg_we`=1 and `reg_dr_addr`=IR[11:9] for exactly one cycle.
  - ADD/AND/NOT only: nzp <= {negative, zero, positive} at the clock edge. LEA does not update nzp.
  - Next PC: pc+1, or pc+1+sext(IR[5:0]) for a taken BR. All PC arithmetic wraps modulo 64.
  - HALT: go to HALT, PC unchanged. All other opcodes: go to FETCH.
- HALT: `halted`=1, `imem_rd`=0, `reg_we`=0. Leaves only on reset.

Rules:
- `imem_ack` is ignored outside FETCH.
- ALU control outputs are decoded combinationally from IR at all times; they are meaningful only in EXECUTE.
- `reg_we` is 0 in every state except EXECUTE.

## Timing
- Reset values: state FETCH, pc 0, IR 16'h0000 (so `alu_op` 00, `source_sel` 00, `ins_immediate` 0), nzp 3'b010, `reg_we` 0, `halted` 0.
- `imem_rd` is 0 while `rst_n` is low and 1 in the first cycle after release.
- Minimum 3 cycles per instruction, with ack in the first FETCH cycle. Each cycle of ack delay adds one cycle.
- Reset asserted in any state, including mid-fetch, returns everything to reset values on the next edge. A late `imem_ack` after reset is treated as a fresh fetch of address 0.
- PC 63 followed by a non-taken instruction goes to PC 0.
- Branch target arithmetic wraps: target = pc + 1 + sext(imm6) mod 64.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants
  - state enum (FETCH, DECODE, EXECUTE, HALT)
  - `alu_op` and `source_sel` encodings, shared with the ALU
  - instruction field positions
- One natural sub-module: `instr_decode`. It is combinational and maps IR to ALU controls, register addresses, write-enable class, nzp-update class, and branch/halt flags.
- The FSM, PC, IR and nzp registers stay in `control_fsm`.

## Test plan
- Reset: hold `rst_n` low 2 cycles → pc=0, nzp=010, `reg_we`=0, `halted`=0; `imem_rd`=1 and `imem_addr`=0 in the first cycle after release.
- ADDI 0x0A63 (dr=R5, sr1=R1, imm=3), acked immediately:
  - DECODE: `reg_sr1_addr`=1.
  - EXECUTE: `alu_op`=00, `source_sel`=00, `ins_immediate`=6'b100011, `reg_we`=1 with `reg_dr_addr`=5 for one cycle.
  - With `positive`=1: nzp becomes 001 and pc goes 0→1.
- Stalled fetch: withhold `imem_ack` for 4 cycles → `imem_rd`=1 with constant `imem_addr`, no state or output change; instruction completes 3 cycles after the ack.
- BRp 0x423E (mask 001, offset −2) at pc=5:
  - nzp=001 → pc becomes 4.
  - nzp=010 → pc becomes 6.
  - `reg_we` stays 0 throughout.
- LEA 0x3002 at pc=63 → `source_sel`=01, `pc`=63, `reg_we`=1; nzp unchanged; next pc=0.
- HALT 0xF000 → `halted`=1 after EXECUTE; `imem_rd`=0 and `imem_ack` pulses ignored; `rst_n` low clears `halted` and restarts at pc=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit core: opcodes, FSM states, ALU encodings, IR field positions.
package cpu_pkg;

  localparam int unsigned CPU_PC_W = 6;
  localparam int unsigned CPU_IW   = 16;
  localparam int unsigned RF_AW    = 3;
  localparam int unsigned IMM_W    = 6;
  localparam int unsigned OPC_W    = 4;
  localparam int unsigned NZP_W    = 3;

  // Instruction field positions
  localparam int unsigned OPC_LSB      = 12;
  localparam int unsigned DR_LSB       = 9;
  localparam int unsigned SR1_LSB      = 6;
  localparam int unsigned IMM_FLAG_BIT = 5;
  localparam int unsigned SR2_LSB      = 0;
  localparam int unsigned IMM_LSB      = 0;

  // Opcodes
  localparam logic [OPC_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OPC_W-1:0] OP_AND  = 4'b0001;
  localparam logic [OPC_W-1:0] OP_NOT  = 4'b0010;
  localparam logic [OPC_W-1:0] OP_LEA  = 4'b0011;
  localparam logic [OPC_W-1:0] OP_BR   = 4'b0100;
  localparam logic [OPC_W-1:0] OP_HALT = 4'b1111;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DECODE  = 2'd1,
    ST_EXECUTE = 2'd2,
    ST_HALT    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_AND = 2'b01,
    ALU_NOT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    SRC_IMM = 2'b00,
    SRC_PC  = 2'b01,
    SRC_REG = 2'b10
  } src_sel_t;

  typedef struct packed {
    alu_op_t            alu_op;
    src_sel_t           source_sel;
    logic [IMM_W-1:0]   imm;
    logic [RF_AW-1:0]   dr;
    logic [RF_AW-1:0]   sr1;
    logic [RF_AW-1:0]   sr2;
    logic               writes_reg;
    logic               updates_nzp;
    logic               is_br;
    logic               is_halt;
  } decode_t;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [CPU_IW-1:0] ir);
    return ir[OPC_LSB +: OPC_W];
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: IR to ALU controls, register addresses and class flags.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [CPU_IW-1:0] ir,
  output decode_t           dec
);

  // Field extraction plus per-opcode control classes
  always_comb begin
    dec             = '0;
    dec.dr          = ir[DR_LSB +: RF_AW];
    dec.sr1         = ir[SR1_LSB +: RF_AW];
    dec.sr2         = ir[SR2_LSB +: RF_AW];
    dec.imm         = ir[IMM_LSB +: IMM_W];
    dec.alu_op      = ALU_ADD;
    dec.source_sel  = ir[IMM_FLAG_BIT] ? SRC_IMM : SRC_REG;
    case (opcode_of(ir))
      OP_ADD: begin
        dec.writes_reg  = 1'b1;
        dec.updates_nzp = 1'b1;
      end
      OP_AND: begin
        dec.alu_op      = ALU_AND;
        dec.writes_reg  = 1'b1;
        dec.updates_nzp = 1'b1;
      end
      OP_NOT: begin
        dec.alu_op      = ALU_NOT;
        dec.writes_reg  = 1'b1;
        dec.updates_nzp = 1'b1;
      end
      OP_LEA: begin
        dec.source_sel  = SRC_PC;
        dec.writes_reg  = 1'b1;
      end
      OP_BR:   dec.is_br   = 1'b1;
      OP_HALT: dec.is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Fetch/decode/execute sequencer: owns PC, IR and NZP, drives memory, register file and ALU controls.
module control_fsm
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W = 6,
  parameter int unsigned IW   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_rd,
  input  logic            imem_ack,
  input  logic [IW-1:0]   imem_data,
  output logic [2:0]      reg_sr1_addr,
  output logic [2:0]      reg_sr2_addr,
  output logic [2:0]      reg_dr_addr,
  output logic            reg_we,
  output logic [1:0]      alu_op,
  output logic [1:0]      source_sel,
  output logic [5:0]      ins_immediate,
  output logic [PC_W-1:0] pc,
  input  logic            negative,
  input  logic            zero,
  input  logic            positive,
  output logic [2:0]      nzp,
  output logic            halted
);

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   ir;
  decode_t         dec;
  logic            fetch_done;
  logic            br_taken;
  logic [PC_W-1:0] pc_exec_nxt;
  logic            imem_rd_nxt;
  logic            reg_we_nxt;
  logic            halted_nxt;

  instr_decode u_decode (
    .ir  (ir),
    .dec (dec)
  );

  // A fetch completes only while the request is actually outstanding
  assign fetch_done  = (state == ST_FETCH) && imem_rd && imem_ack;
  assign br_taken    = dec.is_br && ((dec.dr & nzp) != '0);
  assign pc_exec_nxt = dec.is_halt ? pc
                     : pc + PC_W'(1) + (br_taken ? PC_W'($signed(dec.imm)) : PC_W'(0));

  assign imem_addr     = pc;
  assign reg_sr1_addr  = dec.sr1;
  assign reg_sr2_addr  = dec.sr2;
  assign reg_dr_addr   = dec.dr;
  assign alu_op        = dec.alu_op;
  assign source_sel    = dec.source_sel;
  assign ins_immediate = dec.imm;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH:   if (fetch_done) state_nxt = ST_DECODE;
      ST_DECODE:  state_nxt = ST_EXECUTE;
      ST_EXECUTE: state_nxt = dec.is_halt ? ST_HALT : ST_FETCH;
      ST_HALT:    state_nxt = ST_HALT;
      default:    state_nxt = ST_FETCH;
    endcase
  end

  // Output decode for the registered strobes, based on the state being entered
  always_comb begin
    imem_rd_nxt = 1'b0;
    reg_we_nxt  = 1'b0;
    halted_nxt  = 1'b0;
    case (state_nxt)
      ST_FETCH:   imem_rd_nxt = 1'b1;
      ST_EXECUTE: reg_we_nxt  = dec.writes_reg;
      ST_HALT:    halted_nxt  = 1'b1;
      default: ;
    endcase
  end

  // Architectural registers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ir      <= '0;
      pc      <= '0;
      nzp     <= 3'b010;
      imem_rd <= 1'b0;
      reg_we  <= 1'b0;
      halted  <= 1'b0;
    end else begin
      imem_rd <= imem_rd_nxt;
      reg_we  <= reg_we_nxt;
      halted  <= halted_nxt;
      if (fetch_done) ir <= imem_data;
      if (state == ST_EXECUTE) begin
        pc <= pc_exec_nxt;
        if (dec.updates_nzp) nzp <= {negative, zero, positive};
      end
    end
  end

endmodule
